// File: rtl/pulse_period_monitor.sv
// Purpose: measures the interval between rising edges of pulse_in, declares lock after LOCK_N in-tolerance intervals, flags early/late/missing pulses.
// Latency: every output is registered and updates on the clock edge that samples the event (visible the cycle after the event cycle).
// Backpressure: none; the monitor is a passive observer and never stalls its source.
//
// Ports:
//   clk, rst(active-low async)  - clock and reset
//   enable                      - low forces IDLE (counters/flags held)
//   pulse_in                    - monitored pulse stream, one event per rising edge
//   clr_err                     - synchronous clear of sticky error flags (a same-cycle set wins)
//   pulse_count                 - accepted events since reset, wraps silently
//   last_period                 - gap measured at the most recent tracked event
//   period_ok                   - one-cycle strobe for an in-tolerance interval
//   locked                      - high while in LOCKED
//   err_early/err_late/err_missing - sticky error flags
module pulse_period_monitor #(
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 0,
  parameter int LOCK_N     = 3,
  parameter int CNT_W      = 16,
  parameter int PER_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] pulse_count,
  output logic [PER_W-1:0] last_period,
  output logic             period_ok,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic             err_missing
);

  localparam int CONS_W = $clog2(LOCK_N + 1);

  localparam logic [PER_W-1:0]  PER_LO  = PER_W'(EXP_PERIOD - TOL);
  localparam logic [PER_W-1:0]  PER_HI  = PER_W'(EXP_PERIOD + TOL);
  // Gap value at which the current interval is declared missing.
  localparam logic [PER_W-1:0]  PER_MISS = PER_W'(2 * EXP_PERIOD + 1);
  localparam logic [CONS_W-1:0] LOCK_C  = CONS_W'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t            state;
  logic              pulse_in_d;
  logic [PER_W-1:0]  gap;
  logic [CONS_W-1:0] consec;

  logic              evt;
  logic              is_early;
  logic              in_tol;
  logic [PER_W-1:0]  gap_inc;
  logic [CONS_W-1:0] consec_inc;

  assign evt        = pulse_in & ~pulse_in_d;
  assign is_early   = (gap < PER_LO);
  assign in_tol     = !is_early && (gap <= PER_HI);
  assign gap_inc    = (gap == {PER_W{1'b1}}) ? gap : gap + 1'b1;
  // consec saturates at LOCK_N so a long locked run cannot wrap it.
  assign consec_inc = (consec == LOCK_C) ? consec : consec + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pulse_in_d  <= 1'b0;
      gap         <= '0;
      consec      <= '0;
      pulse_count <= '0;
      last_period <= '0;
      period_ok   <= 1'b0;
      locked      <= 1'b0;
      err_early   <= 1'b0;
      err_late    <= 1'b0;
      err_missing <= 1'b0;
    end else begin
      // Edge detector runs regardless of enable so re-enabling mid-pulse
      // does not manufacture a false event.
      pulse_in_d <= pulse_in;
      period_ok  <= 1'b0;

      // Clear first; any set below overrides it within the same edge.
      if (clr_err) begin
        err_early   <= 1'b0;
        err_late    <= 1'b0;
        err_missing <= 1'b0;
      end

      if (!enable) begin
        state  <= IDLE;
        gap    <= '0;
        consec <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= ACQUIRE;
            gap    <= '0;
            consec <= '0;
            locked <= 1'b0;
          end

          ACQUIRE: begin
            locked <= 1'b0;
            if (evt) begin
              pulse_count <= pulse_count + 1'b1;
              gap         <= PER_W'(1);
              state       <= TRACK;
            end
          end

          TRACK, LOCKED: begin
            if (evt) begin
              pulse_count <= pulse_count + 1'b1;
              last_period <= gap;
              gap         <= PER_W'(1);
              if (in_tol) begin
                period_ok <= 1'b1;
                consec    <= consec_inc;
                if (state == LOCKED || consec_inc == LOCK_C) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end else begin
                  state  <= TRACK;
                  locked <= 1'b0;
                end
              end else begin
                if (is_early) begin
                  err_early <= 1'b1;
                end else begin
                  err_late <= 1'b1;
                end
                consec <= '0;
                state  <= TRACK;
                locked <= 1'b0;
              end
            end else if (gap == PER_MISS) begin
              err_missing <= 1'b1;
              consec      <= '0;
              gap         <= '0;
              state       <= ACQUIRE;
              locked      <= 1'b0;
            end else begin
              gap <= gap_inc;
            end
          end

          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
